fb_arbiter: RTL and testbench

Shares the single-port frame-buffer RAM between the VGA scan-out read stream and a draw client that issues writes and reads. Sits between the VGA timing/pixel block (pixel_addr/pixel_data) and the RAM macro. Display reads have absolute priority. Draw writes are buffered in a small FIFO and drained when the display is idle. Read data is routed back to its owner through a latency-matched tag pipeline.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_wr_fifo.sv | 59 +++++
 rtl/fb_arbiter.sv | 150 +++++++++++++++
 tb/tb_fb_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer arbiter.
// Owner tags, FSM states and default widths shared with the VGA block.
package fb_pkg;

  localparam int FB_ADDR_W = 13;
  localparam int FB_DATA_W = 8;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_DRAW = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Draw-write FIFO of {addr, data}; push refused when full.
// Ports: push_i/pop_i, addr_i/data_i in, addr_o/data_o head, full_o/empty_o.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int AW    = FB_ADDR_W,
  parameter int DW    = FB_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign {addr_o, data_o} = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= {addr_i, data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + PW'(1);
      if (do_pop)  rp_q <= rp_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads > FIFO drain > draw reads.
// Ports: disp_* read stream, wr_*/rd_* draw client, ram_* macro, status.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int WQ_DEPTH = 4,
  parameter int STARVE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic [DATA_W-1:0]   disp_rdata,
  output logic                disp_rvalid,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_rdata,
  output logic                rd_rvalid,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [STARVE_W-1:0] starve_cnt,
  output logic                busy
);

  localparam int NT = RD_LAT + 1;

  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_addr;
  logic [DATA_W-1:0] fifo_data;
  logic              push;
  logic              disp_gnt;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              busy_d;
  tag_t              tag_out;

  fb_state_e           state_q;
  logic                ram_en_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  tag_t                tag_q [NT];
  logic [DATA_W-1:0]   disp_last_q;
  logic [DATA_W-1:0]   rd_last_q;
  logic [STARVE_W-1:0] starve_q;

  assign push     = wr_valid && !fifo_full;
  assign wr_ready = !fifo_full;
  assign rd_ready = rd_gnt;

  fb_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (wr_gnt),
    .addr_i  (wr_addr),
    .data_i  (wr_data),
    .addr_o  (fifo_addr),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Draw reads wait for an empty FIFO so they never overtake a write.
  always_comb begin
    disp_gnt = 1'b0;
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    unique case (1'b1)
      disp_req:                             disp_gnt = 1'b1;
      !disp_req && !fifo_empty:             wr_gnt   = 1'b1;
      !disp_req && fifo_empty && rd_valid:  rd_gnt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      disp_last_q <= '0;
      rd_last_q   <= '0;
      starve_q    <= '0;
      for (int i = 0; i < NT; i++) tag_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (disp_req)  state_q <= SCAN;
        SCAN: if (!disp_req) state_q <= IDLE;
      endcase

      ram_en_q <= disp_gnt || wr_gnt || rd_gnt;
      ram_we_q <= wr_gnt;
      if (disp_gnt)    ram_addr_q <= disp_addr;
      else if (wr_gnt) ram_addr_q <= fifo_addr;
      else if (rd_gnt) ram_addr_q <= rd_addr;
      if (wr_gnt) ram_wdata_q <= fifo_data;

      // Tag stage RD_LAT lines up with ram_rdata of that read.
      tag_q[0] <= tag_t'{
        vld: disp_gnt || rd_gnt,
        own: disp_gnt ? OWN_DISP : OWN_DRAW
      };
      for (int i = 1; i < NT; i++) tag_q[i] <= tag_q[i-1];

      if (disp_rvalid) disp_last_q <= ram_rdata;
      if (rd_rvalid)   rd_last_q   <= ram_rdata;

      if (!fifo_empty && !wr_gnt && starve_q != '1)
        starve_q <= starve_q + STARVE_W'(1);
    end
  end

  assign tag_out     = tag_q[RD_LAT];
  assign disp_rvalid = tag_out.vld && (tag_out.own == OWN_DISP);
  assign rd_rvalid   = tag_out.vld && (tag_out.own == OWN_DRAW);
  assign disp_rdata  = disp_rvalid ? ram_rdata : disp_last_q;
  assign rd_rdata    = rd_rvalid ? ram_rdata : rd_last_q;

  always_comb begin
    busy_d = !fifo_empty;
    for (int i = 0; i < NT; i++) busy_d = busy_d || tag_q[i].vld;
  end

  assign busy       = busy_d;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model plus read/write scoreboards.
// Directed phases: scan, buffered writes, RAW order, priority, reset, saturation.
module tb_fb_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int RL = 3;
  localparam int SW = 16;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } rexp_t;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_rdata;
  logic          rd_rvalid;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [SW-1:0] starve_cnt;
  logic          busy;

  rexp_t            dq[$];
  rexp_t            rq[$];
  logic [AW+DW-1:0] wq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [DW-1:0] mem     [1<<AW];
  bit            memv    [1<<AW];
  logic [DW-1:0] rpipe   [RL];
  logic [DW-1:0] ref_mem [1<<AW];
  bit            refv    [1<<AW];

  fb_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_LAT   (RL),
    .WQ_DEPTH (4),
    .STARVE_W (SW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_rdata    (rd_rdata),
    .rd_rvalid   (rd_rvalid),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .starve_cnt  (starve_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 3);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return refv[a] ? ref_mem[a] : init_val(int'(a));
  endfunction

  // RAM macro model: RL-cycle read latency.
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      memv[ram_addr] <= 1'b1;
    end
    if (ram_en && !ram_we)
      rpipe[0] <= memv[ram_addr] ? mem[ram_addr]
                                 : init_val(int'(ram_addr));
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RL-1];

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare returns, then record this cycle's grants.
  always @(negedge clk) begin
    if (rst_n) begin
      rexp_t e;
      if (disp_rvalid) begin
        if (dq.size() == 0) chk("disp_extra", 1, 0);
        else begin
          e = dq.pop_front();
          chk("disp_lat", cyc_n, e.due);
          chk("disp_rdata", disp_rdata, e.d);
        end
      end else if (dq.size() > 0 && dq[0].due <= cyc_n) begin
        chk("disp_missing", 0, 1);
        void'(dq.pop_front());
      end
      if (rd_rvalid) begin
        if (rq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_lat", cyc_n, e.due);
          chk("rd_rdata", rd_rdata, e.d);
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc_n) begin
        chk("rd_missing", 0, 1);
        void'(rq.pop_front());
      end
      if (ram_en && ram_we) begin
        if (wq.size() == 0) chk("ram_wr_extra", 1, 0);
        else chk("ram_wr", {ram_addr, ram_wdata}, wq.pop_front());
      end
      if (disp_req && rd_valid) chk("rd_ready_disp", rd_ready, 0);
      if (disp_req)
        dq.push_back('{cyc_n + 1 + RL, ref_rd(disp_addr)});
      if (rd_valid && rd_ready)
        rq.push_back('{cyc_n + 1 + RL, ref_rd(rd_addr)});
      if (wr_valid && wr_ready) begin
        wq.push_back({wr_addr, wr_data});
        ref_mem[wr_addr] = wr_data;
        refv[wr_addr]    = 1'b1;
      end
    end
  end

  initial begin
    int da;
    rst_n     = 1'b0;
    disp_req  = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_disp_rvalid", disp_rvalid, 0);
    chk("rst_rd_rvalid", rd_rvalid, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    chk("rst_rd_rdata", rd_rdata, 0);
    chk("rst_starve", starve_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Display scan of 0..9
    disp_req = 1'b1;
    for (int a = 0; a < 10; a++) begin
      disp_addr = AW'(a);
      @(negedge clk);
      if (a > 0) begin
        chk("scan_en", ram_en, 1);
        chk("scan_we", ram_we, 0);
        chk("scan_addr", ram_addr, a - 1);
      end
      cyc();
    end
    da = 10;

    // Buffered writes during scan
    for (int i = 0; i < 4; i++) begin
      disp_addr = AW'(da++);
      wr_valid  = 1'b1;
      wr_addr   = AW'(32'h100 + i);
      wr_data   = DW'(32'hA0 + i);
      @(negedge clk);
      chk("wq_ready", wr_ready, 1);
      cyc();
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      disp_addr = AW'(da++);
      @(negedge clk);
      if (k == 0) begin
        chk("wq_full", wr_ready, 0);
        chk("wq_starve3", starve_cnt, 3);
      end
      cyc();
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk("drain_starve", starve_cnt, 8);
    chk("drain_full", wr_ready, 0);
    cyc();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("drain_we", ram_we, 1);
      chk("drain_addr", ram_addr, 32'h100 + j - 1);
      if (j == 1) chk("drain_ready", wr_ready, 1);
      cyc();
    end
    @(negedge clk);
    chk("drain_idle", ram_en, 0);
    chk("drain_hold", starve_cnt, 8);
    chk("drain_busy", busy, 0);
    cyc();

    // Read-after-write ordering
    wr_valid = 1'b1;
    wr_addr  = AW'(32'h20);
    wr_data  = DW'(32'h55);
    cyc();
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = AW'(32'h20);
    @(negedge clk);
    chk("raw_wait", rd_ready, 0);
    cyc();
    @(negedge clk);
    chk("raw_gnt", rd_ready, 1);
    cyc();
    rd_valid = 1'b0;
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("raw_rvalid", rd_rvalid, 1);
        chk("raw_rdata", rd_rdata, 32'h55);
      end
      if (k == 7) begin
        chk("raw_rvalid_lo", rd_rvalid, 0);
        chk("raw_rdata_hold", rd_rdata, 32'h55);
      end
      cyc();
    end

    // Display wins against a pending draw read
    rd_valid  = 1'b1;
    rd_addr   = AW'(5);
    disp_req  = 1'b1;
    disp_addr = AW'(32'h30);
    @(negedge clk);
    chk("prio_blocked", rd_ready, 0);
    cyc();
    disp_req = 1'b0;
    @(negedge clk);
    chk("prio_resume", rd_ready, 1);
    cyc();
    rd_valid = 1'b0;
    repeat (RL + 4) cyc();

    // Reset with draw reads in flight
    rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(32'h40 + i);
      @(negedge clk);
      chk("inflight_gnt", rd_ready, 1);
      cyc();
    end
    rd_valid = 1'b0;
    rst_n    = 1'b0;
    dq.delete();
    rq.delete();
    wq.delete();
    @(negedge clk);
    chk("mrst_ram_en", ram_en, 0);
    chk("mrst_rd_rvalid", rd_rvalid, 0);
    chk("mrst_rd_rdata", rd_rdata, 0);
    chk("mrst_disp_rdata", disp_rdata, 0);
    chk("mrst_starve", starve_cnt, 0);
    chk("mrst_busy", busy, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < RL + 5; k++) begin
      @(negedge clk);
      chk("post_rd_rvalid", rd_rvalid, 0);
      chk("post_disp_rvalid", disp_rvalid, 0);
      chk("post_ram_en", ram_en, 0);
      cyc();
    end

    // Starvation counter saturation
    disp_req  = 1'b1;
    disp_addr = AW'(32'h1000);
    wr_valid  = 1'b1;
    wr_addr   = AW'(32'h1FF);
    wr_data   = DW'(32'h3C);
    cyc();
    wr_valid = 1'b0;
    for (int k = 1; k <= 65540; k++) begin
      disp_addr = AW'(32'h1000 + (k & 255));
      @(negedge clk);
      if (k == 2)     chk("sat_start", starve_cnt, 1);
      if (k == 65535) chk("sat_edge", starve_cnt, 32'hFFFE);
      if (k == 65536) chk("sat_full", starve_cnt, 32'hFFFF);
      if (k == 65540) chk("sat_nowrap", starve_cnt, 32'hFFFF);
      cyc();
    end
    disp_req = 1'b0;
    repeat (RL + 4) cyc();
    @(negedge clk);
    chk("end_starve", starve_cnt, 32'hFFFF);
    chk("end_busy", busy, 0);
    chk("end_wr_ready", wr_ready, 1);
    chk("end_dq", dq.size(), 0);
    chk("end_rq", rq.size(), 0);
    chk("end_wq", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
